// File: rtl/rggen_bit_field_rwc_mc_if.sv
// Register-block to bit-field connection for rggen fields.
// The register side drives the write strobe; the field side returns its value.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid, write_mask, write_data,
    output read_data, value
  );

  modport register (
    output valid, write_mask, write_data,
    input  read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_rwc_mc.sv
// Read/write field with NUM_CLEARS hardware clear sources, each level- or edge-qualified.
// Optional applied-clear counter is enabled by defining RGGEN_RWC_MC_CLEAR_COUNT_EN.
module rggen_bit_field_rwc_mc #(
  parameter int                          WIDTH          = 8,
  parameter logic [WIDTH-1:0]            INITIAL_VALUE  = '0,
  parameter int                          NUM_CLEARS     = 2,
  parameter logic [NUM_CLEARS*WIDTH-1:0] CLEAR_MASK     = '1,
  parameter logic [NUM_CLEARS-1:0]       CLEAR_EDGE     = '0,
  parameter int                          WRITE_PRIORITY = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rggen_bit_field_if.bit_field  bit_field_if,
  input  logic [NUM_CLEARS-1:0] i_clear,
  output logic [NUM_CLEARS-1:0] o_clear_ack,
  output logic [WIDTH-1:0]      o_value
`ifdef RGGEN_RWC_MC_CLEAR_COUNT_EN
  ,
  output logic [7:0]            o_clear_count
`endif
);
  logic [WIDTH-1:0]      value_q, value_d;
  logic [NUM_CLEARS-1:0] pending_q, pending_d;
  logic [NUM_CLEARS-1:0] clear_prev_q, clear_prev_d;
  logic [NUM_CLEARS-1:0] clear_ack_q, clear_ack_d;
  logic [NUM_CLEARS-1:0] clear_event;
  logic [NUM_CLEARS-1:0] clear_req;
  logic [NUM_CLEARS-1:0] clear_applied;
  logic [WIDTH-1:0]      clear_mask;
  logic [WIDTH-1:0]      write_bits;
  logic                  write_defers;

  // Clear handshake: a request (level, or rising edge) is held as pending until applied;
  // o_clear_ack pulses for one cycle after the edge that applied it. There is no back-pressure.
  always_comb begin
    clear_event  = i_clear & ~(CLEAR_EDGE & clear_prev_q);
    clear_req    = clear_event | pending_q;
    clear_prev_d = i_clear;
    clear_mask   = '0;
    for (int j = 0; j < NUM_CLEARS; j++) begin
      if (clear_req[j]) begin
        clear_mask = clear_mask | CLEAR_MASK[j*WIDTH +: WIDTH];
      end
    end
    write_bits   = bit_field_if.valid ? bit_field_if.write_mask : '0;
    write_defers = (WRITE_PRIORITY != 0) && bit_field_if.valid;

    value_d       = value_q;
    pending_d     = '0;
    clear_applied = '0;
    if (write_defers) begin
      value_d   = (value_q & ~write_bits) | (bit_field_if.write_data & write_bits);
      pending_d = clear_req;
    end else begin
      // Clear bits beat write bits on overlap.
      value_d       = (INITIAL_VALUE & clear_mask)
                    | (bit_field_if.write_data & write_bits & ~clear_mask)
                    | (value_q & ~write_bits & ~clear_mask);
      clear_applied = clear_req;
    end
    clear_ack_d = clear_applied;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q      <= INITIAL_VALUE;
      pending_q    <= '0;
      clear_prev_q <= '0;
      clear_ack_q  <= '0;
    end else begin
      value_q      <= value_d;
      pending_q    <= pending_d;
      clear_prev_q <= clear_prev_d;
      clear_ack_q  <= clear_ack_d;
    end
  end

  assign bit_field_if.read_data = value_q;
  assign bit_field_if.value     = value_q;
  assign o_value                = value_q;
  assign o_clear_ack            = clear_ack_q;

`ifdef RGGEN_RWC_MC_CLEAR_COUNT_EN
  logic [7:0] clear_count_q, clear_count_d;
  logic       count_zero;

  // A full-width write of the initial value resets the count, taking precedence over increments.
  always_comb begin
    count_zero    = bit_field_if.valid && (&bit_field_if.write_mask)
                 && (bit_field_if.write_data == INITIAL_VALUE);
    clear_count_d = clear_count_q;
    if (count_zero) begin
      clear_count_d = 8'h00;
    end else if ((|clear_applied) && (clear_count_q != 8'hFF)) begin
      clear_count_d = clear_count_q + 8'h01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clear_count_q <= 8'h00;
    end else begin
      clear_count_q <= clear_count_d;
    end
  end

  assign o_clear_count = clear_count_q;
`endif
endmodule
